// File: rtl/ahb_lite_dma_master_if.sv
// AHB-Lite bus bundle between the DMA initiator and the system fabric.
// The master modport is the initiator view; the slave modport is the fabric view.
interface ahb_lite_dma_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_dma_master.sv
// Single-channel AHB-Lite word-copy engine: alternating single reads and writes
// from src to dst, one-cycle done pulse with sticky error on an ERROR response.
module ahb_lite_dma_master #(
  parameter int          COUNT_WIDTH = 16,
  parameter logic [3:0]  HPROT_VAL   = 4'b0011
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  ahb_lite_dma_master_if.master  bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4,
    S_ABORT   = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, src_d;
  logic [31:0]            dst_q, dst_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]            buf_q, buf_d;
  logic [31:0]            haddr_q, haddr_d;
  logic [1:0]             htrans_q, htrans_d;
  logic                   hwrite_q, hwrite_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   abort_q, abort_d;
  logic                   unused_s;

  assign unused_s = ^{src_addr[1:0], dst_addr[1:0]};

  // State and registered bus/status outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      src_q    <= 32'h0000_0000;
      dst_q    <= 32'h0000_0000;
      rem_q    <= {COUNT_WIDTH{1'b0}};
      buf_q    <= 32'h0000_0000;
      haddr_q  <= 32'h0000_0000;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      buf_q    <= buf_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      abort_q  <= abort_d;
    end
  end

  // Next-state, datapath and address-phase output decode
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    abort_d  = abort_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    htrans_d = HTRANS_IDLE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = {src_addr[31:2], 2'b00};
          dst_d   = {dst_addr[31:2], 2'b00};
          rem_d   = word_count;
          error_d = 1'b0;
          abort_d = 1'b0;
          busy_d  = 1'b1;
          state_d = (word_count == {COUNT_WIDTH{1'b0}}) ? S_FINISH : S_RD_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (bus.HREADY) begin
          state_d = S_RD_DATA;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        if (bus.HRESP) begin
          abort_d = 1'b1;
          state_d = bus.HREADY ? S_FINISH : S_ABORT;
        end else if (bus.HREADY) begin
          buf_d   = bus.HRDATA;
          src_d   = src_q + 32'd4;
          state_d = S_WR_ADDR;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_WR_ADDR: begin
        if (bus.HREADY) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_WR_ADDR;
        end
      end
      S_WR_DATA: begin
        if (bus.HRESP) begin
          abort_d = 1'b1;
          state_d = bus.HREADY ? S_FINISH : S_ABORT;
        end else if (bus.HREADY) begin
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - COUNT_WIDTH'(1);
          state_d = (rem_q == COUNT_WIDTH'(1)) ? S_FINISH : S_RD_ADDR;
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_ABORT: begin
        if (bus.HREADY) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_FINISH: begin
        // done, busy drop and error all land on the same edge
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = abort_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus address-phase registers track the state being entered
    if (state_d == S_RD_ADDR) begin
      htrans_d = HTRANS_NONSEQ;
      haddr_d  = src_d;
      hwrite_d = 1'b0;
    end else if (state_d == S_WR_ADDR) begin
      htrans_d = HTRANS_NONSEQ;
      haddr_d  = dst_d;
      hwrite_d = 1'b1;
    end else begin
      htrans_d = HTRANS_IDLE;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HWDATA    = buf_q;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_dma_master.sv
// Randomized bench for ahb_lite_dma_master: a wait-state/error-injecting AHB slave
// plus a transfer-list reference model derived from the copy rules.
module tb_ahb_lite_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error;

  ahb_lite_dma_master_if bus();

  ahb_lite_dma_master #(.COUNT_WIDTH(16), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       obs_q[$];
  logic [31:0] pre_mem [bit [31:0]];
  logic [31:0] wr_mem  [bit [31:0]];
  int n_checks = 0;
  int n_errors = 0;
  int wait_cfg = 0, err_rd_idx = -1, rd_idx = 0;
  int nonseq_cnt = 0, hw_unstable = 0, bad_htrans = 0;

  // slave data-phase state
  bit          dp_active = 1'b0, dp_write = 1'b0, dp_err = 1'b0, dp_seen = 1'b0;
  int          wait_left = 0, err_stage = 0;
  logic [31:0] dp_addr, dp_wdata;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return pre_mem.exists(a) ? pre_mem[a] : pat(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return wr_mem.exists(a) ? wr_mem[a] : ref_rd(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Behavioural AHB slave: samples at the edge, drives responses 1 time unit later
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'h0;
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        dp_active = 1'b0;
      end else begin
        if (dp_active) begin
          if (dp_write) begin
            if (!dp_seen) begin
              dp_wdata = bus.HWDATA;
              dp_seen  = 1'b1;
            end else if (bus.HWDATA !== dp_wdata) begin
              hw_unstable++;
            end
          end
          if (bus.HREADY) begin
            if (!bus.HRESP) begin
              obs_q.push_back('{dp_addr, dp_write, dp_write ? bus.HWDATA : bus.HRDATA});
              if (dp_write) wr_mem[dp_addr] = bus.HWDATA;
            end
            dp_active = 1'b0;
          end
        end
        if (bus.HTRANS != 2'b00 && bus.HTRANS != 2'b10) bad_htrans++;
        if (bus.HTRANS == 2'b10 && bus.HREADY) begin
          nonseq_cnt++;
          dp_active = 1'b1;
          dp_addr   = bus.HADDR;
          dp_write  = bus.HWRITE;
          dp_seen   = 1'b0;
          wait_left = wait_cfg;
          err_stage = 0;
          dp_err    = !bus.HWRITE && (rd_idx == err_rd_idx);
          if (!bus.HWRITE) rd_idx++;
        end
      end
      #1;
      if (!dp_active) begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
      end else if (dp_err) begin
        bus.HRESP = 1'b1;
        bus.HREADY = (err_stage != 0);
        err_stage = 1;
      end else if (wait_left > 0) begin
        bus.HREADY = 1'b0; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
        wait_left--;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        bus.HRDATA = dp_write ? $urandom : slv_rd(dp_addr);
      end
    end
  end

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input int waits, input int err_idx, input bit restart);
    logic [31:0] s, d;
    bit  exp_err;
    int  k, exp_lat, lat, busy_bad;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    exp_err = (err_idx >= 0) && (err_idx < n);
    k       = exp_err ? err_idx : n;
    // each word: read addr + read data + write addr + write data, waits on both data phases
    exp_lat = 2 + k * (4 + 2 * waits) + (exp_err ? 3 : 0);
    wait_cfg = waits; err_rd_idx = err_idx; rd_idx = 0;
    obs_q.delete(); nonseq_cnt = 0; hw_unstable = 0; bad_htrans = 0;
    @(negedge HCLK);
    start = 1'b1; src_addr = src; dst_addr = dst; word_count = 16'(n);
    @(posedge HCLK); #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; word_count = 16'($urandom);
    lat = 1; busy_bad = 0;
    check("err_clear_on_start", error, 1'b0);
    while (!done && lat < 400) begin
      if (!busy) busy_bad++;
      start = (restart && lat == 4);
      @(posedge HCLK); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_lat);
    check("done", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("error", error, exp_err);
    check("busy_gap", busy_bad, 0);
    check("nonseq_cnt", nonseq_cnt, exp_err ? 2 * k + 1 : 2 * k);
    check("xfer_cnt", obs_q.size(), 2 * k);
    if (obs_q.size() == 2 * k) begin
      for (int i = 0; i < k; i++) begin
        check("rd_addr", obs_q[2*i].addr, s + 32'(4 * i));
        check("rd_dir", obs_q[2*i].wr, 1'b0);
        check("wr_addr", obs_q[2*i+1].addr, d + 32'(4 * i));
        check("wr_dir", obs_q[2*i+1].wr, 1'b1);
        check("wr_data", obs_q[2*i+1].data, ref_rd(s + 32'(4 * i)));
      end
    end
    @(posedge HCLK); #1;
    check("done_one_cycle", done, 1'b0);
    check("error_hold", error, exp_err);
    check("hwdata_stable", hw_unstable, 0);
    check("htrans_legal", bad_htrans, 0);
  endtask

  initial begin
    int done_seen;
    HRESETn = 1'b0; start = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; word_count = 16'h0;
    pre_mem[32'h0000_0100] = 32'hDEAD_BEEF;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwrite", bus.HWRITE, 1'b0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("hsize", bus.HSIZE, 3'b010);
    check("hburst", bus.HBURST, 3'b000);
    check("hprot", bus.HPROT, 4'b0011);
    check("hmastlock", bus.HMASTLOCK, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    run_copy(32'h0000_0100, 32'h2000_0000, 1, 0, -1, 1'b0);
    run_copy(32'h0000_0100, 32'h2000_0000, 3, 2, -1, 1'b0);
    run_copy(32'h0000_0100, 32'h2000_0000, 0, 0, -1, 1'b0);
    run_copy(32'h0000_0100, 32'h2000_1000, 3, 0, 1, 1'b0);
    repeat (3) @(posedge HCLK);
    #1;
    check("error_sticky", error, 1'b1);
    run_copy(32'hFFFF_FFFC, 32'h4000_0000, 2, 1, -1, 1'b1);

    // asynchronous reset during a write data phase
    wait_cfg = 2; err_rd_idx = -1; rd_idx = 0;
    @(negedge HCLK);
    start = 1'b1; src_addr = 32'h0000_0200; dst_addr = 32'h3000_0000; word_count = 16'd3;
    @(posedge HCLK); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge HCLK); #2;
      if (dp_active && dp_write) break;
    end
    check("reached_wr_data", {31'b0, dp_active && dp_write}, 32'd1);
    HRESETn = 1'b0;
    #1;
    check("arst_htrans", bus.HTRANS, 2'b00);
    check("arst_haddr", bus.HADDR, 32'h0);
    check("arst_hwrite", bus.HWRITE, 1'b0);
    check("arst_hwdata", bus.HWDATA, 32'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_error", error, 1'b0);
    done_seen = 0;
    repeat (3) begin
      @(posedge HCLK); #1;
      if (done) done_seen++;
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) begin
      @(posedge HCLK); #1;
      if (done || busy) done_seen++;
    end
    check("no_done_after_reset", done_seen, 0);
    run_copy(32'h0000_0300, 32'h3000_0100, 2, 0, -1, 1'b0);

    for (int it = 0; it < 8; it++) begin
      int n, w, e;
      logic [31:0] s, d;
      n = $urandom_range(0, 5);
      w = $urandom_range(0, 2);
      e = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      s = $urandom & 32'h0FFF_FFFF;
      d = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
      run_copy(s, d, n, w, e, 1'($urandom_range(0, 1)) & (n > 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
